// File: rtl/clock_gate_ctrl.sv
// Multi-channel clock-gating controller: per-channel idle hysteresis FSM, latch-based
// glitch-free gate, test-mode force-on and saturating suppressed-edge counters.
module clock_gate_ctrl #(
   parameter int unsigned N_CH        = 2,
   parameter int unsigned IDLE_CYCLES = 8,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [N_CH-1:0]       en,
   input  logic                  force_on,
   input  logic                  clr_stats,
   output logic [N_CH-1:0]       gclk,
   output logic [N_CH-1:0]       clk_active,
   output logic [N_CH*CNT_W-1:0] off_cycles
);

   localparam int unsigned DRAIN_W = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_INIT =
      DRAIN_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);

   typedef enum logic [1:0] {StOff, StOn, StDrain} state_e;

   state_e             state_q [N_CH];
   state_e             state_d [N_CH];
   logic [DRAIN_W-1:0] cnt_q   [N_CH];
   logic [DRAIN_W-1:0] cnt_d   [N_CH];
   logic [CNT_W-1:0]   off_q   [N_CH];
   logic [N_CH-1:0]    gate_q;
   logic [N_CH-1:0]    latch_q;

   always_comb begin
      for (int i = 0; i < int'(N_CH); i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            StOn: begin
               if (!en[i]) begin
                  if (IDLE_CYCLES == 0) begin
                     state_d[i] = StOff;
                  end else begin
                     state_d[i] = StDrain;
                     cnt_d[i]   = DRAIN_INIT;
                  end
               end
            end
            StDrain: begin
               if (en[i]) begin
                  state_d[i] = StOn;
               end else if (cnt_q[i] == '0) begin
                  state_d[i] = StOff;
               end else begin
                  cnt_d[i] = cnt_q[i] - DRAIN_W'(1);
               end
            end
            StOff: begin
               if (en[i]) state_d[i] = StOn;
            end
            default: state_d[i] = StOff;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gate_q     <= '0;
         clk_active <= '0;
         for (int i = 0; i < int'(N_CH); i++) begin
            state_q[i] <= StOff;
            cnt_q[i]   <= '0;
            off_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < int'(N_CH); i++) begin
            state_q[i]    <= state_d[i];
            cnt_q[i]      <= cnt_d[i];
            gate_q[i]     <= (state_d[i] != StOff) | force_on;
            clk_active[i] <= (state_d[i] != StOff);
            // gate_q low before this edge means the edge was suppressed
            if (clr_stats) begin
               off_q[i] <= '0;
            end else if (!gate_q[i] && (off_q[i] != {CNT_W{1'b1}})) begin
               off_q[i] <= off_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // Transparent only while clk is low, so the enable never changes under a high phase.
   always_latch begin
      if (!reset_n) begin
         latch_q <= '0;
      end else if (!clk) begin
         latch_q <= gate_q;
      end
   end

   assign gclk = {N_CH{clk}} & latch_q;

   for (genvar g = 0; g < int'(N_CH); g++) begin : g_pack
      assign off_cycles[g*CNT_W +: CNT_W] = off_q[g];
   end

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Randomized self-checking bench for clock_gate_ctrl, covering an IDLE_CYCLES=8/CNT_W=16 build
// and an IDLE_CYCLES=0/CNT_W=4 build driven by the same stimulus.
`timescale 1ps/1ps
module tb_clock_gate_ctrl;

   localparam int N     = 2;
   localparam int HALF  = 4000;
   localparam int NEVER = 1000;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [N-1:0] en = '0;
   logic         force_on = 1'b0;
   logic         clr_stats = 1'b0;
   logic [N-1:0] gclk_a, gclk_b, act_a, act_b;
   logic [2*16-1:0] off_a;
   logic [2*4-1:0]  off_b;

   always #HALF clk = ~clk;

   clock_gate_ctrl #(.N_CH(2), .IDLE_CYCLES(8), .CNT_W(16)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .en(en), .force_on(force_on), .clr_stats(clr_stats),
      .gclk(gclk_a), .clk_active(act_a), .off_cycles(off_a)
   );

   clock_gate_ctrl #(.N_CH(2), .IDLE_CYCLES(0), .CNT_W(4)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .en(en), .force_on(force_on), .clr_stats(clr_stats),
      .gclk(gclk_b), .clk_active(act_b), .off_cycles(off_b)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: a channel may clock at edge m if en was last seen high within
   // IDLE_CYCLES edges before edge m-1 (age counts edges since en was last sampled high).
   int idle_v [2] = '{8, 0};
   int max_v  [2] = '{65535, 15};
   int age       [2][N];
   bit gate_m    [2][N];
   bit gate_prev [2][N];
   int off_m     [2][N];
   int edges_exp [4];

   task automatic model_reset();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < N; i++) begin
            age[d][i]       = NEVER;
            gate_m[d][i]    = 1'b0;
            gate_prev[d][i] = 1'b0;
            off_m[d][i]     = 0;
         end
   endtask

   task automatic model_edge();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < N; i++) begin
            gate_prev[d][i] = gate_m[d][i];
            if (gate_m[d][i]) edges_exp[d*2+i]++;
            if (clr_stats) off_m[d][i] = 0;
            else if (!gate_m[d][i] && off_m[d][i] < max_v[d]) off_m[d][i]++;
            if (en[i]) age[d][i] = 0;
            else if (age[d][i] < NEVER) age[d][i]++;
            gate_m[d][i] = (age[d][i] <= idle_v[d]) || force_on;
         end
   endtask

   task automatic check_outputs();
      for (int i = 0; i < N; i++) begin
         check($sformatf("gclk_a[%0d]", i), longint'(gclk_a[i]), longint'(gate_prev[0][i]));
         check($sformatf("gclk_b[%0d]", i), longint'(gclk_b[i]), longint'(gate_prev[1][i]));
         check($sformatf("active_a[%0d]", i), longint'(act_a[i]),
               longint'(age[0][i] <= idle_v[0]));
         check($sformatf("active_b[%0d]", i), longint'(act_b[i]),
               longint'(age[1][i] <= idle_v[1]));
         check($sformatf("off_a[%0d]", i), longint'(off_a[i*16 +: 16]), longint'(off_m[0][i]));
         check($sformatf("off_b[%0d]", i), longint'(off_b[i*4 +: 4]), longint'(off_m[1][i]));
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_gclk_a"}, longint'(gclk_a), 0);
      check({tag, "_gclk_b"}, longint'(gclk_b), 0);
      check({tag, "_act_a"}, longint'(act_a), 0);
      check({tag, "_act_b"}, longint'(act_b), 0);
      check({tag, "_off_a"}, longint'(off_a), 0);
      check({tag, "_off_b"}, longint'(off_b), 0);
   endtask

   // Pulse-width monitor and edge scoreboard; index 0,1 = build A, 2,3 = build B.
   wire [3:0] gclk_all = {gclk_b, gclk_a};
   for (genvar k = 0; k < 4; k++) begin : g_mon
      longint t_rise = 0;
      bit     armed  = 1'b0;
      int     seen   = 0;
      always @(posedge gclk_all[k]) begin
         t_rise = $time;
         armed  = 1'b1;
         seen++;
      end
      always @(negedge gclk_all[k]) begin
         if (armed && reset_n) check($sformatf("pulse_w[%0d]", k), $time - t_rise, HALF);
         armed = 1'b0;
      end
   end

   initial begin
      #500_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 4; k++) edges_exp[k] = 0;
      model_reset();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      check_reset_outputs("post_reset");

      // Legacy complementary pattern, two full periods
      for (int c = 0; c < 2 * 2148; c++) begin
         en[0] = ((c % 2148) < 1024);
         en[1] = ~en[0];
         step();
      end

      // Hysteresis: short dip keeps the clock, long dip drains then gates
      en = 2'b11;
      repeat (20) step();
      en[0] = 1'b0;
      repeat (5) step();
      en[0] = 1'b1;
      repeat (20) step();
      en[0] = 1'b0;
      repeat (20) step();
      en[0] = 1'b1;
      repeat (10) step();

      // Force-on while both channels are OFF
      en = 2'b00;
      repeat (30) step();
      force_on = 1'b1;
      repeat (10) step();
      force_on = 1'b0;
      repeat (10) step();

      // Saturation (4-bit build) and clear
      repeat (40) step();
      clr_stats = 1'b1;
      step();
      clr_stats = 1'b0;
      repeat (10) step();

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 9) == 0) en[i] = ~en[i];
         force_on  = ($urandom_range(0, 99) < 3);
         clr_stats = ($urandom_range(0, 63) == 0);
         step();
      end

      // Asynchronous reset in the middle of a gclk high phase
      en = 2'b11;
      force_on = 1'b0;
      clr_stats = 1'b0;
      repeat (12) step();
      #1000;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("held_rst");
      @(negedge clk);
      reset_n = 1'b1;
      repeat (5) step();

      for (int c = 0; c < 1000; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 5) == 0) en[i] = ~en[i];
         force_on  = ($urandom_range(0, 99) < 2);
         clr_stats = ($urandom_range(0, 99) == 0);
         step();
      end
      en = '0;
      force_on = 1'b0;
      clr_stats = 1'b0;
      repeat (12) step();
      @(negedge clk);

      check("edges[0]", g_mon[0].seen, edges_exp[0]);
      check("edges[1]", g_mon[1].seen, edges_exp[1]);
      check("edges[2]", g_mon[2].seen, edges_exp[2]);
      check("edges[3]", g_mon[3].seen, edges_exp[3]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
